// File: rtl/output_device_ctrl.sv
// rtl/output_device_ctrl.sv - output-write responder: device registers plus console TX FIFO
// Optional write-strobe port dev_wr_strobe is enabled by defining OUTPUT_DEV_STROBE_EN.
module output_device_ctrl #(
  parameter int         NUM_REGS   = 4,
  parameter logic [7:0] CONSOLE_ID = 8'h10,
  parameter int         PTR_W      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   output_is_write,
  input  logic [7:0]             io_device_id,
  input  logic [31:0]            output_devices_value,
  output logic [NUM_REGS*32-1:0] dev_regs,
`ifdef OUTPUT_DEV_STROBE_EN
  output logic [NUM_REGS-1:0]    dev_wr_strobe,
`endif
  output logic                   console_valid,
  output logic [7:0]             console_data,
  input  logic                   console_ready,
  output logic [PTR_W:0]         console_level,
  output logic                   console_overflow
);

  localparam int             DEPTH      = 1 << PTR_W;
  localparam logic [PTR_W:0] LP_FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_LVL_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] LP_PTR_ONE = PTR_W'(1);

  logic [NUM_REGS-1:0]   w_reg_we;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_accept;

  logic [NUM_REGS*32-1:0] r_dev_regs;
  logic [7:0]             r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_level;
  logic                   r_overflow;

  always_comb begin
    w_reg_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_reg_we[i] = output_is_write && (io_device_id == 8'(i));
    end
  end

  assign w_push   = output_is_write && (io_device_id == CONSOLE_ID);
  assign w_full   = (r_level == LP_FULL);
  assign w_pop    = (r_level != '0) && console_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still take the push.
  assign w_accept = w_push && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dev_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_reg_we[i]) r_dev_regs[32*i +: 32] <= output_devices_value;
      end
    end
  end

  // Storage needs no reset: entries are only observable between the pointers.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= output_devices_value[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      if (w_push && !w_accept) r_overflow <= 1'b1;
      unique case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + LP_LVL_ONE;
        2'b01:   r_level <= r_level - LP_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef OUTPUT_DEV_STROBE_EN
  logic [NUM_REGS-1:0] r_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_strobe <= '0;
    else       r_strobe <= w_reg_we;
  end

  assign dev_wr_strobe = r_strobe;
`endif

  assign dev_regs         = r_dev_regs;
  assign console_valid    = (r_level != '0);
  assign console_data     = r_mem[r_rd_ptr];
  assign console_level    = r_level;
  assign console_overflow = r_overflow;

endmodule
